// File: rtl/time_disp.sv
`default_nettype none
// ============================================================================
// Module   : time_disp
// Purpose  : Sequential double-dabble conversion of sec/min/hour into BCD,
//            driving a 6-digit multiplexed active-low seven-segment display.
//            Optional macro LEAD_ZERO_BLANK_EN blanks a zero hour-tens digit.
// Revision : 1.0 - initial release
// ============================================================================
module time_disp (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [5:0] hour,
    input  logic       scan_tick,
    output logic [7:0] seg,
    output logic [5:0] sel,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [2:0] C_LAST_SHIFT = 3'd5;
    localparam logic [1:0] C_LAST_FIELD = 2'd2;
    localparam logic [2:0] C_LAST_DIGIT = 3'd5;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_field;
    logic [2:0] r_shift_cnt;
    logic [5:0] r_snap_min;
    logic [5:0] r_snap_hour;
    logic [5:0] r_bin;
    logic [7:0] r_bcd;
    logic [7:0] r_shadow_sec;
    logic [7:0] r_shadow_min;
    logic [7:0] r_shadow_hour;
    logic [7:0] r_disp_sec;
    logic [7:0] r_disp_min;
    logic [7:0] r_disp_hour;
    logic [2:0] r_idx;
    logic [7:0] r_seg;
    logic [5:0] r_sel;

    logic [7:0] w_bcd_adj;
    logic [7:0] w_bcd_shifted;
    logic [3:0] w_digit;
    logic [7:0] w_seg;
    logic [5:0] w_sel;

    function automatic logic [7:0] seg7(input logic [3:0] v);
        logic [7:0] r;
        case (v)
            4'd0:    r = 8'hC0;
            4'd1:    r = 8'hF9;
            4'd2:    r = 8'hA4;
            4'd3:    r = 8'hB0;
            4'd4:    r = 8'h99;
            4'd5:    r = 8'h92;
            4'd6:    r = 8'h82;
            4'd7:    r = 8'hF8;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h90;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = LOAD;
            LOAD:    w_state_nxt = SHIFT;
            SHIFT: begin
                if (r_shift_cnt == C_LAST_SHIFT)
                    w_state_nxt = (r_field == C_LAST_FIELD) ? COMMIT : LOAD;
            end
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    // ---------------- double-dabble datapath ----------------
    always_comb begin
        w_bcd_adj = r_bcd;
        if (r_bcd[3:0] >= 4'd5) w_bcd_adj[3:0] = r_bcd[3:0] + 4'd3;
        if (r_bcd[7:4] >= 4'd5) w_bcd_adj[7:4] = r_bcd[7:4] + 4'd3;
        w_bcd_shifted = {w_bcd_adj[6:0], r_bin[5]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_field       <= 2'd0;
            r_shift_cnt   <= 3'd0;
            r_snap_min    <= 6'd0;
            r_snap_hour   <= 6'd0;
            r_bin         <= 6'd0;
            r_bcd         <= 8'd0;
            r_shadow_sec  <= 8'd0;
            r_shadow_min  <= 8'd0;
            r_shadow_hour <= 8'd0;
            r_disp_sec    <= 8'd0;
            r_disp_min    <= 8'd0;
            r_disp_hour   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: r_field <= 2'd0;
                LOAD: begin
                    r_bcd       <= 8'd0;
                    r_shift_cnt <= 3'd0;
                    // All three fields are captured together so a pass is coherent
                    if (r_field == 2'd0) begin
                        r_bin       <= sec;
                        r_snap_min  <= min;
                        r_snap_hour <= hour;
                    end else if (r_field == 2'd1) begin
                        r_bin <= r_snap_min;
                    end else begin
                        r_bin <= r_snap_hour;
                    end
                end
                SHIFT: begin
                    r_bcd       <= w_bcd_shifted;
                    r_bin       <= {r_bin[4:0], 1'b0};
                    r_shift_cnt <= r_shift_cnt + 3'd1;
                    if (r_shift_cnt == C_LAST_SHIFT) begin
                        case (r_field)
                            2'd0:    r_shadow_sec  <= w_bcd_shifted;
                            2'd1:    r_shadow_min  <= w_bcd_shifted;
                            default: r_shadow_hour <= w_bcd_shifted;
                        endcase
                        r_field <= r_field + 2'd1;
                    end
                end
                COMMIT: begin
                    r_disp_sec  <= r_shadow_sec;
                    r_disp_min  <= r_shadow_min;
                    r_disp_hour <= r_shadow_hour;
                    r_field     <= 2'd0;
                end
                default: r_field <= 2'd0;
            endcase
        end
    end

    // ---------------- digit scan ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 3'd0;
        end else if (r_idx > C_LAST_DIGIT) begin
            r_idx <= 3'd0;
        end else if (scan_tick) begin
            r_idx <= (r_idx == C_LAST_DIGIT) ? 3'd0 : r_idx + 3'd1;
        end
    end

    always_comb begin
        w_digit = 4'hF;
        case (r_idx)
            3'd0:    w_digit = r_disp_sec[3:0];
            3'd1:    w_digit = r_disp_sec[7:4];
            3'd2:    w_digit = r_disp_min[3:0];
            3'd3:    w_digit = r_disp_min[7:4];
            3'd4:    w_digit = r_disp_hour[3:0];
            3'd5:    w_digit = r_disp_hour[7:4];
            default: w_digit = 4'hF;
        endcase
        w_seg = seg7(w_digit);
        // Decimal points separate the sec/min and min/hour pairs
        if (r_idx == 3'd2 || r_idx == 3'd4) w_seg[7] = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        if (r_idx == 3'd5 && r_disp_hour[7:4] == 4'd0) w_seg = 8'hFF;
`endif
        w_sel = ~(6'b000001 << r_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= 8'hFF;
            r_sel <= 6'b111111;
        end else begin
            r_seg <= w_seg;
            r_sel <= w_sel;
        end
    end

    assign seg = r_seg;
    assign sel = r_sel;

endmodule
`default_nettype wire

// File: doc/time_disp.md
TIME_DISP -- requirements
Module: time_disp

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sec  input  6  binary seconds, 0..63 accepted.
- min  input  6  binary minutes, 0..63 accepted.
- hour  input  6  binary hours, 0..63 accepted.
- scan_tick  input  1  one-cycle enable that advances the digit scan.
- seg  output  8  active-low segments; bit7=dp, bits6..0 = g,f,e,d,c,b,a.
- sel  output  6  active-low one-hot digit enable; bit k drives digit k.
- busy  output  1  high while a conversion pass is in progress.

Function
REQ-002 Conversion SHALL be sequential shift-add-3 (double dabble), one field at a time, with no combinational divide or modulo.
REQ-003 The FSM SHALL have the states IDLE, LOAD, SHIFT and COMMIT.
REQ-004 IDLE SHALL go to LOAD on the next cycle (free-running); busy SHALL be 0 only in IDLE.
REQ-005 LOAD SHALL snapshot sec, min and hour together in the same cycle, for field 0 only, so one pass is coherent even if the inputs change mid-pass.
REQ-006 Each field SHALL take 1 LOAD/prep cycle plus 6 SHIFT cycles; the order SHALL be sec, min, hour.
REQ-007 The add-3 step SHALL apply to each 4-bit BCD nibble that is >=5 before each shift.
REQ-008 The shadow BCD result SHALL be 8 bits per field (tens, units); input 63 SHALL yield tens=6, units=3.
REQ-009 COMMIT SHALL copy all three shadow results to the display BCD registers in a single cycle, then return to IDLE.
REQ-010 Pass length SHALL be 22 cycles from LOAD to COMMIT inclusive; display registers SHALL update only in COMMIT.
REQ-011 Out-of-range inputs (e.g. sec=60) SHALL be converted and displayed as-is, with no clamping.
REQ-012 The scan index SHALL be a 3-bit counter 0..5 that advances by 1 when scan_tick=1 and wraps 5->0.
REQ-013 Index values 6 and 7 are unreachable; if they occur, the index SHALL force to 0 on the next cycle.
REQ-014 Digit mapping SHALL be: 0=sec units, 1=sec tens, 2=min units, 3=min tens, 4=hour units, 5=hour tens.
REQ-015 sel and seg SHALL be registered and SHALL reflect the scan index with 1-cycle latency.
REQ-016 sel SHALL be ~(6'b000001 << index).
REQ-017 The segment decode SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, dp off).
REQ-018 BCD values 10..15 SHALL decode to FF (blank).
REQ-019 The dp segment SHALL be lit (bit7=0) on digits 2 and 4 only.
REQ-020 When scan_tick coincides with COMMIT, the new index and the new BCD data SHALL both be used on the following cycle.

Reset
REQ-021 While rst=1, the block SHALL set: FSM=IDLE, scan index=0, shadow and display BCD=0, busy=0, seg=8'hFF, sel=6'b111111.
REQ-022 Reset asserted mid-pass SHALL abort the pass; no partial COMMIT SHALL occur.
REQ-023 On the first clk edge after rst falls, the outputs SHALL be seg=8'hC0 and sel=6'b111110.
REQ-024 The first COMMIT after reset SHALL occur 23 cycles after rst falls.

Configuration
REQ-025 Macro LEAD_ZERO_BLANK_EN SHALL control hour-tens blanking.
- Defined: when the hour tens BCD=0, digit 5 SHALL output seg=8'hFF; sel behaviour SHALL be unchanged.
- Undefined: digit 5 SHALL show 0 normally (8'hC0).
- All other digits SHALL be unaffected in both cases.

Verification
REQ-026 Reset release with sec=0, min=0, hour=12, scan_tick held 1 -> after 1 pass, digits 0..5 SHALL read C0, C0, 40, C0, 24, F9.
REQ-027 sec=59, min=59, hour=23, then all inputs change to 0 during SHIFT of field 1 -> this pass SHALL commit 59/59/23 and the next pass SHALL commit 0/0/0.
REQ-028 sec=60 for one pass -> digit 1 SHALL read 82 and digit 0 SHALL read C0.
REQ-029 hour=5, scan to digit 5 -> seg SHALL be FF with LEAD_ZERO_BLANK_EN defined and C0 without it.
REQ-030 rst pulsed during field 2 SHIFT -> display BCD SHALL be 0, with no COMMIT until a full 22-cycle pass completes.
REQ-031 scan_tick=1 for 7 consecutive cycles from index 0 -> sel SHALL step through 111110..011111 and then back to 111110.
